// File: rtl/ram_access_ctrl.sv
// Load/store initiator for the byte-lane RAM peripheral: one request in flight.
// Define LSU_MISALIGN_CHK_EN to reject misaligned half/word requests with an error response.
module ram_access_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic [3:0]            ram_wr_en_o,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wr_data_o,
   output logic                  ram_rd_en_o,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
   input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

   // Handshake: a request transfers on a rising edge where req_valid_i and
   // req_ready_o are both high; rsp_valid_o is a single-cycle pulse with no
   // backpressure, one per accepted request.

   typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

   localparam logic [1:0] LAT = 2'(RD_LATENCY);

   state_t                state;
   logic [1:0]            size_q;
   logic                  unsigned_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0]            lat_cnt;

   logic                  bad_req;
   logic [3:0]            wr_be;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] ld_data;

   // Ready drops combinationally during reset so nothing is accepted then.
   assign req_ready_o   = (state == IDLE) && !rst;
   assign ram_wr_addr_o = (state == WR) ? addr_q : '0;
   assign ram_rd_addr_o = ram_rd_en_o ? addr_q : '0;

   always_comb begin
      bad_req = (req_size_i == 2'b11);
`ifdef LSU_MISALIGN_CHK_EN
      if (req_size_i == 2'b01 && req_addr_i[0])
         bad_req = 1'b1;
      if (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00)
         bad_req = 1'b1;
`endif
   end

   always_comb begin
      wr_be   = 4'b1111;
      wr_data = req_wdata_i;
      case (req_size_i)
         2'b00: begin
            wr_be   = 4'b0001 << req_addr_i[1:0];
            wr_data = {4{req_wdata_i[7:0]}};
         end
         2'b01: begin
            wr_be   = 4'b0011 << {req_addr_i[1], 1'b0};
            wr_data = {2{req_wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted = ram_rd_data_i;
      ld_data = ram_rd_data_i;
      case (size_q)
         2'b00: begin
            shifted = ram_rd_data_i >> {addr_q[1:0], 3'b000};
            ld_data = {{(DATA_WIDTH-8){~unsigned_q & shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            shifted = ram_rd_data_i >> {addr_q[1], 4'b0000};
            ld_data = {{(DATA_WIDTH-16){~unsigned_q & shifted[15]}}, shifted[15:0]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         size_q        <= '0;
         unsigned_q    <= 1'b0;
         addr_q        <= '0;
         lat_cnt       <= '0;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_err_o     <= 1'b0;
         ram_wr_en_o   <= '0;
         ram_wr_data_o <= '0;
         ram_rd_en_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  size_q     <= req_size_i;
                  unsigned_q <= req_unsigned_i;
                  addr_q     <= req_addr_i;
                  lat_cnt    <= '0;
                  if (bad_req) begin
                     state       <= RSP;
                     rsp_valid_o <= 1'b1;
                     rsp_err_o   <= 1'b1;
                     rsp_rdata_o <= '0;
                  end else if (req_we_i) begin
                     state         <= WR;
                     ram_wr_en_o   <= wr_be;
                     ram_wr_data_o <= wr_data;
                  end else begin
                     state       <= RD;
                     ram_rd_en_o <= 1'b1;
                  end
               end
            end
            WR: begin
               ram_wr_en_o   <= '0;
               ram_wr_data_o <= '0;
               rsp_valid_o   <= 1'b1;
               rsp_err_o     <= 1'b0;
               rsp_rdata_o   <= '0;
               state         <= RSP;
            end
            RD: begin
               // Enable is a single pulse; data is taken RD_LATENCY cycles later.
               ram_rd_en_o <= 1'b0;
               if (lat_cnt == LAT) begin
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b0;
                  rsp_rdata_o <= ld_data;
                  state       <= RSP;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            RSP: begin
               rsp_valid_o <= 1'b0;
               rsp_err_o   <= 1'b0;
               rsp_rdata_o <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: byte-array reference memory, response queue,
// directed cases plus randomized load/store traffic.
module tb_ram_access_ctrl;

   localparam int MAIN_LAT = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = '0;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        req_ready_o, rsp_valid_o, rsp_err_o, ram_rd_en_o;
   logic [31:0] rsp_rdata_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_addr_o, ram_rd_data_i;
   logic [3:0]  ram_wr_en_o;

   logic        v3 = 1'b0;
   logic        ready3, rsp_valid3, rsp_err3, rd_en3;
   logic [31:0] rsp_rdata3, wr_addr3, wr_data3, rd_addr3, rd_data3;
   logic [3:0]  wr_en3;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_full_cnt = 0;

   logic [48:0] exp_q[$];
   logic [7:0]  ram_mem[0:1023];
   logic [7:0]  exp_mem[0:1023];
   logic [31:0] rd_pipe[0:2];
   logic [31:0] rd3_pipe[0:2];

   ram_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(MAIN_LAT)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
      .ram_rd_en_o(ram_rd_en_o), .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_data_i(ram_rd_data_i)
   );

   ram_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .req_valid_i(v3), .req_ready_o(ready3), .req_we_i(req_we_i),
      .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid3), .rsp_rdata_o(rsp_rdata3), .rsp_err_o(rsp_err3),
      .ram_wr_en_o(wr_en3), .ram_wr_addr_o(wr_addr3), .ram_wr_data_o(wr_data3),
      .ram_rd_en_o(rd_en3), .ram_rd_addr_o(rd_addr3), .ram_rd_data_i(rd_data3)
   );

   // ---------------- clock / reset / cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] init_byte(input int i);
      return 8'(i * 73 + 29);
   endfunction

   // ---------------- RAM peripheral models
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) ram_mem[i] <= init_byte(i);
      end else begin
         for (int i = 0; i < 4; i++)
            if (ram_wr_en_o[i]) ram_mem[{ram_wr_addr_o[9:2], 2'(i)}] <= ram_wr_data_o[8*i +: 8];
      end
      rd_pipe[0] <= ram_rd_en_o ?
         {ram_mem[{ram_rd_addr_o[9:2], 2'd3}], ram_mem[{ram_rd_addr_o[9:2], 2'd2}],
          ram_mem[{ram_rd_addr_o[9:2], 2'd1}], ram_mem[{ram_rd_addr_o[9:2], 2'd0}]} : $urandom;
      rd_pipe[1] <= rd_pipe[0];
      rd_pipe[2] <= rd_pipe[1];
      rd3_pipe[0] <= rd_en3 ? 32'h8001_5555 : $urandom;
      rd3_pipe[1] <= rd3_pipe[0];
      rd3_pipe[2] <= rd3_pipe[1];
   end
   assign ram_rd_data_i = rd_pipe[MAIN_LAT-1];
   assign rd_data3      = rd3_pipe[2];

   // ---------------- reference model
   function automatic logic [32:0] model(input logic we, input logic [1:0] sz, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] wd);
      int a, b;
      logic bad;
      logic [31:0] v;
      a = int'(addr[9:0]);
      bad = (sz == 2'b11);
`ifdef LSU_MISALIGN_CHK_EN
      if ((sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)) bad = 1'b1;
`endif
      if (bad) return {1'b1, 32'h0};
      if (sz == 2'b00) b = a;
      else if (sz == 2'b01) b = a - (a % 2);
      else b = a - (a % 4);
      if (we) begin
         exp_mem[b] = wd[7:0];
         if (sz != 2'b00) exp_mem[b+1] = wd[15:8];
         if (sz == 2'b10) begin
            exp_mem[b+2] = wd[23:16];
            exp_mem[b+3] = wd[31:24];
         end
         return {1'b0, 32'h0};
      end
      if (sz == 2'b00) begin
         v = {24'h0, exp_mem[b]};
         if (!uns && v[7]) v = v - 32'h100;
      end else if (sz == 2'b01) begin
         v = {16'h0, exp_mem[b+1], exp_mem[b]};
         if (!uns && v[15]) v = v - 32'h1_0000;
      end else begin
         v = {exp_mem[b+3], exp_mem[b+2], exp_mem[b+1], exp_mem[b]};
      end
      return {1'b0, v};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks (called at a negedge, return at the negedge after accept)
   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, output int acc);
      int n;
      int lat;
      logic [32:0] r;
      req_valid_i = 1'b1;
      req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
      req_addr_i = addr; req_wdata_i = wd;
      n = 0;
      while (!req_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready_o) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got ready=0 expected ready=1 within 20 cycles");
         req_valid_i = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc;
      r = model(we, sz, uns, addr, wd);
      lat = r[32] ? 1 : (we ? 2 : 2 + MAIN_LAT);
      exp_q.push_back({16'(cyc + lat), r});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      req_valid_i = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic lat3_test(input logic uns, input logic [31:0] exp);
      int t, n;
      v3 = 1'b1; req_we_i = 1'b0; req_size_i = 2'b01; req_unsigned_i = uns; req_addr_i = 32'h102;
      n = 0;
      while (!ready3 && n < 20) begin
         @(negedge clk);
         n++;
      end
      t = cyc;
      @(posedge clk);
      @(negedge clk);
      v3 = 1'b0;
      n = 0;
      while (!rsp_valid3 && n < 12) begin
         @(negedge clk);
         n++;
      end
      chk("lat3_rsp_cycle", 32'(cyc - t), 32'd5);
      chk("lat3_rdata", rsp_rdata3, exp);
      chk("lat3_err", 32'(rsp_err3), 32'd0);
      @(negedge clk);
   endtask

   // ---------------- monitor / scoreboard
   always @(negedge clk) begin
      logic [48:0] e;
      if (!rst) begin
         if (ram_wr_en_o != 4'b0 || ram_rd_en_o)
            chk("wr_rd_exclusive", 32'(ram_wr_en_o != 4'b0 && ram_rd_en_o), 32'd0);
         if (ram_wr_en_o == 4'hF) wr_full_cnt++;
         if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
               e = exp_q.pop_front();
               chk("rsp_cycle", 32'(cyc), 32'(e[48:33]));
               chk("rsp_err", 32'(rsp_err_o), 32'(e[32]));
               chk("rsp_rdata", rsp_rdata_o, e[31:0]);
            end
         end
      end
   end

   // ---------------- stimulus
   initial begin
      int t, n, bad;
      int acc[4];
      for (int i = 0; i < 1024; i++) exp_mem[i] = init_byte(i);
      repeat (3) @(negedge clk);
      chk("reset_ready", 32'(req_ready_o), 32'd0);
      chk("reset_outputs", {rsp_valid_o, rsp_err_o, ram_rd_en_o, ram_wr_en_o}, 32'd0);
      chk("reset_rdata", rsp_rdata_o, 32'd0);
      rst = 1'b0;
      #1 chk("ready_after_reset", 32'(req_ready_o), 32'd1);
      @(negedge clk);

      // Byte store 0xA5 at 0x103
      do_req(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, t);
      chk("byte_wr_en", 32'(ram_wr_en_o), 32'h8);
      chk("byte_wr_data", ram_wr_data_o, 32'hA5A5_A5A5);
      chk("byte_wr_addr", ram_wr_addr_o, 32'h103);

      // Word 0 at 0x100, half 0x1234 at 0x102, signed byte load from 0x103
      do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, t);
      do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_1234, t);
      chk("half_wr_en", 32'(ram_wr_en_o), 32'hC);
      chk("half_wr_data", ram_wr_data_o, 32'h1234_1234);
      do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, t);
      chk("load_rd_en", 32'(ram_rd_en_o), 32'd1);
      chk("load_rd_addr", ram_rd_addr_o, 32'h103);
      chk("load_no_wr", 32'(ram_wr_en_o), 32'd0);

      // Half 0x8001 at 0x102, signed and unsigned half loads
      do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_8001, t);
      do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, t);
      do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, t);

      // Reserved size: error at T+1 with no RAM access
      do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, t);
      chk("err_no_ram", {31'h0, ram_rd_en_o} | 32'(ram_wr_en_o), 32'd0);
      do_req(1'b1, 2'b11, 1'b0, 32'h104, 32'hFFFF_FFFF, t);
      // Misaligned word load and half store
      do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, t);
      do_req(1'b1, 2'b01, 1'b0, 32'h105, 32'h0000_BEEF, t);
      do_req(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, t);
      idle(8);

      // Reset in the cycle after a load is accepted
      req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h200;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1 chk("ready_after_abort", 32'(req_ready_o), 32'd1);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid_o || ram_rd_en_o || ram_wr_en_o != 4'b0) bad++;
      end
      chk("abort_quiet", 32'(bad), 32'd0);
      // The aborted reset reloads the RAM image, so resync the reference memory.
      for (int i = 0; i < 1024; i++) exp_mem[i] = init_byte(i);

      // RD_LATENCY=3 instance
      lat3_test(1'b0, 32'hFFFF_8001);
      lat3_test(1'b1, 32'h0000_8001);

      // Back-to-back word stores with valid held
      wr_full_cnt = 0;
      for (int i = 0; i < 4; i++)
         do_req(1'b1, 2'b10, 1'b0, 32'h300 + 32'(4 * i), $urandom, acc[i]);
      idle(6);
      chk("held_wr_pulses", 32'(wr_full_cnt), 32'd4);
      for (int i = 1; i < 4; i++) chk("held_spacing", 32'(acc[i] - acc[i-1]), 32'd3);

      // Randomized traffic
      for (int i = 0; i < 200; i++) begin
         logic [1:0] sz;
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 1023)), $urandom, t);
         n = $urandom_range(0, 2);
         if (n > 0) idle(n);
      end
      idle(1);
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("responses_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
